// File: rtl/hysteresis_bram_reader_if.sv
// Bus bundle between the hysteresis reader, its source BRAM read port and
// the downstream highlight FIFO write port.
//
// Handshake: the BRAM read port has no flow control. An address driven in
// cycle N returns data in cycle N+1. The FIFO write port transfers one byte in
// every cycle where highlight_wr_en=1. The writer asserts highlight_wr_en only
// while highlight_full=0, so highlight_full acts as an inverted ready and
// highlight_wr_en acts as a valid that never waits on ready.
interface hysteresis_bram_reader_if #(
  parameter int AW = 20
);
  logic [AW-1:0] hysteresis_bram_rd_addr;
  logic [7:0]    hysteresis_bram_rd_data;
  logic [7:0]    highlight_din;
  logic          highlight_wr_en;
  logic          highlight_full;

  modport master (
    output hysteresis_bram_rd_addr,
    input  hysteresis_bram_rd_data,
    output highlight_din,
    output highlight_wr_en,
    input  highlight_full
  );

  modport slave (
    input  hysteresis_bram_rd_addr,
    output hysteresis_bram_rd_data,
    input  highlight_din,
    input  highlight_wr_en,
    output highlight_full
  );
endinterface

// File: rtl/hysteresis_bram_reader.sv
// Hysteresis BRAM reader: after hough_start, it scans the frame buffer in
// raster order and streams every pixel into the highlight FIFO. It absorbs
// the 1-cycle BRAM latency with a 2-entry skid buffer and honours FIFO full.
// When the frame is finished it pulses hysteresis_read_done and publishes
// the count of nonzero pixels.
//
// Optional feature: define HYST_READER_ROI_MASK_EN to zero every pixel
// outside the ROI rectangle before it enters the skid buffer. The ROI_*
// parameters exist only in that build.
module hysteresis_bram_reader #(
  parameter int WIDTH              = 1280,
  parameter int HEIGHT             = 720,
  parameter int REDUCED_IMAGE_SIZE = WIDTH * HEIGHT
`ifdef HYST_READER_ROI_MASK_EN
  ,
  parameter int ROI_X0             = 0,
  parameter int ROI_X1             = WIDTH - 1,
  parameter int ROI_Y0             = 0,
  parameter int ROI_Y1             = HEIGHT - 1
`endif
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      hough_start,
  hysteresis_bram_reader_if.master                  bram_fifo,
  output logic                                      hysteresis_read_done,
  output logic                                      busy,
  output logic [$clog2(REDUCED_IMAGE_SIZE+1)-1:0]   edge_count,
  output logic [1:0]                                dbg_state
);

  localparam int AW = $clog2(REDUCED_IMAGE_SIZE);
  localparam int CW = $clog2(REDUCED_IMAGE_SIZE + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(REDUCED_IMAGE_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_last_addr;
  logic          r_in_flight;
  logic [7:0]    r_skid [2];
  logic          r_head;
  logic [1:0]    r_skid_cnt;
  logic [CW-1:0] r_acc;
  logic [CW-1:0] r_edge_count;
  logic          r_busy;
  logic          r_done;

  logic          w_pop;
  logic [1:0]    w_cnt_next;
  logic          w_issue_start;
  logic          w_issue_stream;
  logic          w_issue;
  logic [AW-1:0] w_issue_addr;
  logic [7:0]    w_head;
  logic [7:0]    w_pix_in;
  logic          w_tail;
  logic [CW-1:0] w_acc_next;

  // A pixel leaves whenever the skid holds one and the FIFO has room.
  assign w_pop  = (r_skid_cnt != 2'd0) && !bram_fifo.highlight_full;
  assign w_head = r_skid[r_head];
  assign w_tail = r_head ^ r_skid_cnt[0];

  // Occupancy after this cycle's pop and the capture of last cycle's read.
  // Issuing only while it is below 2 keeps skid plus in-flight within two
  // entries, and still lets one read per cycle run when the FIFO drains.
  assign w_cnt_next = r_skid_cnt - {1'b0, w_pop} + {1'b0, r_in_flight};

  // The start cycle issues address 0 so that the first write lands two
  // cycles after hough_start.
  assign w_issue_start  = (r_state == S_IDLE) && hough_start;
  assign w_issue_stream = (r_state == S_STREAM) && (w_cnt_next < 2'd2);
  assign w_issue        = w_issue_start || w_issue_stream;
  assign w_issue_addr   = w_issue_start ? '0 : r_rd_ptr;

  assign w_acc_next = r_acc + CW'(w_pop && (w_head != 8'd0));

`ifdef HYST_READER_ROI_MASK_EN
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] COL_LAST = XW'(WIDTH - 1);
  localparam logic [XW-1:0] ROI_X0_C = XW'(ROI_X0);
  localparam logic [XW-1:0] ROI_X1_C = XW'(ROI_X1);
  localparam logic [YW-1:0] ROI_Y0_C = YW'(ROI_Y0);
  localparam logic [YW-1:0] ROI_Y1_C = YW'(ROI_Y1);

  logic [XW-1:0] r_col;
  logic [YW-1:0] r_row;
  logic          w_in_roi;

  // The row/col counters follow the pixel that is about to enter the skid tail.
  always_ff @(posedge clock) begin
    if (reset || w_issue_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_in_flight) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign w_in_roi = (r_col >= ROI_X0_C) && (r_col <= ROI_X1_C) &&
                    (r_row >= ROI_Y0_C) && (r_row <= ROI_Y1_C);
  assign w_pix_in = w_in_roi ? bram_fifo.hysteresis_bram_rd_data : 8'd0;
`else
  assign w_pix_in = bram_fifo.hysteresis_bram_rd_data;
`endif

  // Skid buffer: capture returning read data and pop the head toward the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_skid[0]   <= 8'd0;
      r_skid[1]   <= 8'd0;
      r_head      <= 1'b0;
      r_skid_cnt  <= 2'd0;
      r_in_flight <= 1'b0;
    end else begin
      if (r_in_flight) begin
        r_skid[w_tail] <= w_pix_in;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_skid_cnt  <= w_cnt_next;
      r_in_flight <= w_issue;
    end
  end

  // Control FSM: read pointer, edge accumulation, busy/done and result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rd_ptr     <= '0;
      r_last_addr  <= '0;
      r_acc        <= '0;
      r_edge_count <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_issue) begin
        r_last_addr <= w_issue_addr;
        r_rd_ptr    <= w_issue_addr + 1'b1;
      end
      r_acc <= w_issue_start ? '0 : w_acc_next;
      case (r_state)
        S_IDLE: begin
          if (hough_start) begin
            r_busy  <= 1'b1;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_issue_stream && (r_rd_ptr == LAST_ADDR)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_cnt_next == 2'd0) begin
            r_done       <= 1'b1;
            r_edge_count <= w_acc_next;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bram_fifo.hysteresis_bram_rd_addr = w_issue ? w_issue_addr : r_last_addr;
  assign bram_fifo.highlight_din           = w_head;
  assign bram_fifo.highlight_wr_en         = w_pop;
  assign hysteresis_read_done              = r_done;
  assign busy                              = r_busy;
  assign edge_count                        = r_edge_count;
  assign dbg_state                         = r_state;

endmodule

// File: tb/tb_hysteresis_bram_reader.sv
// Bench for hysteresis_bram_reader on an 8x4 frame: BRAM model, FIFO full
// driver, write monitor with an expected-pixel queue, directed scenarios.
module tb_hysteresis_bram_reader;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = 5;
  localparam int CW = 6;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  logic hough_start;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic          hysteresis_read_done;
  logic          busy;
  logic [CW-1:0] edge_count;
  logic [1:0]    dbg_state;

  hysteresis_bram_reader_if #(.AW(AW)) bus ();

  hysteresis_bram_reader #(
    .WIDTH  (W),
    .HEIGHT (H)
`ifdef HYST_READER_ROI_MASK_EN
    ,
    .ROI_X0 (2),
    .ROI_X1 (5),
    .ROI_Y0 (1),
    .ROI_Y1 (2)
`endif
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .hough_start          (hough_start),
    .bram_fifo            (bus),
    .hysteresis_read_done (hysteresis_read_done),
    .busy                 (busy),
    .edge_count           (edge_count),
    .dbg_state            (dbg_state)
  );

  // BRAM model: registered read, data valid one cycle after the address
  logic [7:0] mem [N];
  always @(posedge clock) bus.hysteresis_bram_rd_data <= mem[bus.hysteresis_bram_rd_addr];

  // scoreboard state
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int done_count = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  int start_cyc = 0;
  int exp_edge = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // FIFO full driver: mode 0 never full, mode 1 alternating plus a 5-cycle burst
  int full_mode = 0;
  int burst_left = 0;
  bit burst_done = 1'b0;
  initial begin
    bus.highlight_full = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (full_mode == 1) begin
        if (wr_count >= 10 && !burst_done) begin
          burst_left = 5;
          burst_done = 1'b1;
        end
        if (burst_left > 0) begin
          bus.highlight_full = 1'b1;
          burst_left--;
        end else begin
          bus.highlight_full = cyc[0];
        end
      end else begin
        bus.highlight_full = 1'b0;
      end
    end
  end

  // write monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (bus.highlight_wr_en) begin
      check("wr_while_full", 32'(bus.highlight_full), 0);
      if (exp_q.size() == 0) check("write_overrun", wr_count + 1, N);
      else check("pixel", 32'(bus.highlight_din), 32'(exp_q.pop_front()));
      if (wr_count == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      wr_count++;
    end
    if (hysteresis_read_done) begin
      done_count++;
      check("edge_count_at_done", 32'(edge_count), exp_edge);
    end
  end

  function automatic logic [7:0] exp_pixel(input int idx, input logic [7:0] v);
`ifdef HYST_READER_ROI_MASK_EN
    int row = idx / W;
    int col = idx % W;
    if (col >= 2 && col <= 5 && row >= 1 && row <= 2) return v;
    return 8'd0;
`else
    if (idx < 0) return 8'd0;
    return v;
`endif
  endfunction

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // kind 0: BRAM[i]=i, 1: all zero, 2: all 0xFF
  task automatic load_frame(input int kind);
    logic [7:0] v;
    logic [7:0] ev;
    exp_q.delete();
    exp_edge = 0;
    wr_count = 0;
    done_count = 0;
    for (int i = 0; i < N; i++) begin
      v = (kind == 0) ? 8'(i) : (kind == 1) ? 8'h00 : 8'hFF;
      mem[i] = v;
      ev = exp_pixel(i, v);
      exp_q.push_back(ev);
      if (ev != 8'd0) exp_edge++;
    end
  endtask

  task automatic pulse_start;
    start_cyc = cyc;
    hough_start = 1'b1;
    step(1);
    hough_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    int d0 = done_count;
    while (done_count == d0 && k < budget) begin
      step(1);
      k++;
    end
    check("done_seen", 32'(done_count != d0), 1);
    check("busy_after_done", 32'(busy), 0);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (wr_count < n && k < budget) begin
      step(1);
      k++;
    end
    check("reached_write", 32'(wr_count >= n), 1);
  endtask

  task automatic frame_checks;
    check("write_count", wr_count, N);
    check("queue_left", exp_q.size(), 0);
    check("done_count", done_count, 1);
    check("edge_count", 32'(edge_count), exp_edge);
  endtask

  initial begin
    reset = 1'b1;
    hough_start = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 8'd0;
    step(3);
    check("rst_wr_en", 32'(bus.highlight_wr_en), 0);
    check("rst_done", 32'(hysteresis_read_done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_edge_count", 32'(edge_count), 0);
    check("rst_rd_addr", 32'(bus.hysteresis_bram_rd_addr), 0);
    check("rst_din", 32'(bus.highlight_din), 0);
    check("rst_state", 32'(dbg_state), 0);
    reset = 1'b0;
    step(2);

    // basic stream
    full_mode = 0;
    load_frame(0);
    pulse_start();
    check("busy_during", 32'(busy), 1);
    wait_done(200);
    frame_checks();
    check("first_latency", first_wr_cyc - start_cyc, 2);
    check("stream_span", last_wr_cyc - first_wr_cyc, N - 1);
    step(3);

    // backpressure
    load_frame(0);
    burst_done = 1'b0;
    full_mode = 1;
    pulse_start();
    wait_done(400);
    frame_checks();
    check("burst_seen", 32'(burst_done), 1);
    full_mode = 0;
    step(3);

    // all zeros
    load_frame(1);
    pulse_start();
    wait_done(200);
    frame_checks();
    step(3);

    // start while busy
    load_frame(0);
    pulse_start();
    wait_writes(12, 100);
    pulse_start();
    wait_done(200);
    frame_checks();
    step(10);
    check("single_done_later", done_count, 1);
    check("extra_writes_later", wr_count, N);
    check("idle_after_ignored_start", 32'(dbg_state), 0);

    // reset mid-frame
    load_frame(0);
    pulse_start();
    wait_writes(20, 100);
    reset = 1'b1;
    step(1);
    check("midrst_wr_en", 32'(bus.highlight_wr_en), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_state", 32'(dbg_state), 0);
    check("midrst_rd_addr", 32'(bus.hysteresis_bram_rd_addr), 0);
    check("midrst_din", 32'(bus.highlight_din), 0);
    check("midrst_edge_count", 32'(edge_count), 0);
    reset = 1'b0;
    step(10);
    check("midrst_no_done", done_count, 0);
    load_frame(0);
    pulse_start();
    wait_done(200);
    frame_checks();
    check("restart_latency", first_wr_cyc - start_cyc, 2);
    step(3);

`ifdef HYST_READER_ROI_MASK_EN
    // ROI mask over an all-0xFF frame
    load_frame(2);
    pulse_start();
    wait_done(200);
    frame_checks();
    step(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
